// File: rtl/cnode_dose_seq.sv
// cnode_dose_seq
//   Dosing sequencer for one N-inlet concentration node. A run opens each
//   enabled inlet in turn for its dwell, with a one-cycle all-closed gap in
//   front of every channel slot. It then holds the mix phase and opens the
//   outlet for a flush. Every output is a flop.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), async active-low reset
//   start_i            run request, honoured only in IDLE
//   abort_i            cancel the current run (ignored in IDLE)
//   dwell_i            per-channel open time, channel i at [i*CNT_W +: CNT_W]
//   ch_en_i            channel enable mask
//   mix_cycles_i       mix-hold cycles
//   flush_cycles_i     outlet-open cycles
//   valve_o            inlet valve drives (one-hot or zero)
//   mix_en_o           mix phase active
//   outlet_open_o      outlet valve drive
//   cur_ch_o           slot being dosed, 0 outside the dose phase
//   busy_o             high in every non-IDLE state
//   done_o             one-cycle pulse in the DONE state
//   aborted_o          one-cycle pulse after an abort
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; config registers hold the last run
// DOSE_GAP  | one all-closed cycle at the head of slot idx
// DOSE_OPEN | valve[idx] open, cnt counts the remaining dwell down
// MIX       | mix_en high, cnt counts the remaining mix cycles down
// FLUSH     | outlet open, cnt counts the remaining flush cycles down
// DONE      | done pulse, back to IDLE on the next edge

module cnode_dose_seq #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [N_CH*CNT_W-1:0] dwell_i,
  input  logic [N_CH-1:0]       ch_en_i,
  input  logic [CNT_W-1:0]      mix_cycles_i,
  input  logic [CNT_W-1:0]      flush_cycles_i,
  output logic [N_CH-1:0]       valve_o,
  output logic                  mix_en_o,
  output logic                  outlet_open_o,
  output logic [IDX_W-1:0]      cur_ch_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOSE_GAP,
    S_DOSE_OPEN,
    S_MIX,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [N_CH*CNT_W-1:0] dwell_q;
  logic [N_CH-1:0]       ch_en_q;
  logic [CNT_W-1:0]      mix_q;
  logic [CNT_W-1:0]      flush_q;

  logic [N_CH-1:0]       valve_q, valve_d;
  logic                  mix_en_q;
  logic                  outlet_q;
  logic [IDX_W-1:0]      cur_ch_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;

  logic                  accept_d;
  logic                  abort_d;
  logic                  last_slot;
  logic [CNT_W-1:0]      slot_dwell;
  state_t                tail_state;
  logic [CNT_W-1:0]      tail_cnt;

  assign last_slot = (idx_q == LAST_IDX);

  // Effective dwell of the current slot; a masked channel counts as zero.
  always_comb begin
    slot_dwell = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IDX_W'(i) && ch_en_q[i]) begin
        slot_dwell = dwell_q[i*CNT_W +: CNT_W];
      end
    end
  end

  // First phase after the dose slots; zero-length phases are skipped so they
  // take no cycles at all.
  always_comb begin
    if (mix_q != '0) begin
      tail_state = S_MIX;
      tail_cnt   = mix_q - ONE;
    end else if (flush_q != '0) begin
      tail_state = S_FLUSH;
      tail_cnt   = flush_q - ONE;
    end else begin
      tail_state = S_DONE;
      tail_cnt   = '0;
    end
  end

  // Counters are loaded with length-1 on phase entry and the phase ends when
  // they read zero, so an all-ones dwell is held for its full length.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    abort_d  = 1'b0;
    if (state_q != S_IDLE && abort_i) begin
      abort_d = 1'b1;
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            accept_d = 1'b1;
            state_d  = S_DOSE_GAP;
            idx_d    = '0;
          end
        end
        S_DOSE_GAP: begin
          if (slot_dwell != '0) begin
            state_d = S_DOSE_OPEN;
            cnt_d   = slot_dwell - ONE;
          end else if (last_slot) begin
            state_d = tail_state;
            cnt_d   = tail_cnt;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DOSE_OPEN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (last_slot) begin
            state_d = tail_state;
            cnt_d   = tail_cnt;
            idx_d   = '0;
          end else begin
            state_d = S_DOSE_GAP;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        S_MIX: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (flush_q != '0) begin
            state_d = S_FLUSH;
            cnt_d   = flush_q - ONE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_FLUSH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    valve_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      valve_d[i] = (state_d == S_DOSE_OPEN) && (idx_d == IDX_W'(i));
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register, and the phase drives stay mutually exclusive by construction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      dwell_q   <= '0;
      ch_en_q   <= '0;
      mix_q     <= '0;
      flush_q   <= '0;
      valve_q   <= '0;
      mix_en_q  <= 1'b0;
      outlet_q  <= 1'b0;
      cur_ch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (accept_d) begin
        dwell_q <= dwell_i;
        ch_en_q <= ch_en_i;
        mix_q   <= mix_cycles_i;
        flush_q <= flush_cycles_i;
      end
      valve_q   <= valve_d;
      mix_en_q  <= (state_d == S_MIX);
      outlet_q  <= (state_d == S_FLUSH);
      cur_ch_q  <= (state_d == S_DOSE_GAP || state_d == S_DOSE_OPEN) ? idx_d : '0;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      aborted_q <= abort_d;
    end
  end

  assign valve_o       = valve_q;
  assign mix_en_o      = mix_en_q;
  assign outlet_open_o = outlet_q;
  assign cur_ch_o      = cur_ch_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;

endmodule

// File: tb/tb_cnode_dose_seq.sv
// Bench for cnode_dose_seq. The reference model turns each accepted start
// into the full per-cycle output trace of the run (gap + dwell per slot, mix,
// flush, done) and queues it. A monitor on the falling edge pops one entry per
// cycle (all-zero when nothing is queued) and compares it with the DUT.

module tb_cnode_dose_seq;

  localparam int N_CH  = 3;
  localparam int CNT_W = 16;
  localparam int IDX_W = 2;

  typedef struct packed {
    logic [N_CH-1:0]  valve;
    logic             mix;
    logic             outlet;
    logic [IDX_W-1:0] cur_ch;
    logic             busy;
    logic             done;
    logic             aborted;
  } obs_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  start_i;
  logic                  abort_i;
  logic [N_CH*CNT_W-1:0] dwell_i;
  logic [N_CH-1:0]       ch_en_i;
  logic [CNT_W-1:0]      mix_cycles_i;
  logic [CNT_W-1:0]      flush_cycles_i;
  logic [N_CH-1:0]       valve_o;
  logic                  mix_en_o;
  logic                  outlet_open_o;
  logic [IDX_W-1:0]      cur_ch_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  aborted_o;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_last = -1;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];
  obs_t ab_o;
  obs_t act_o;
  obs_t want_o;

  cnode_dose_seq #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .dwell_i       (dwell_i),
    .ch_en_i       (ch_en_i),
    .mix_cycles_i  (mix_cycles_i),
    .flush_cycles_i(flush_cycles_i),
    .valve_o       (valve_o),
    .mix_en_o      (mix_en_o),
    .outlet_open_o (outlet_open_o),
    .cur_ch_o      (cur_ch_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected trace of a whole run; returns its length in cycles.
  function automatic int push_run(input logic [N_CH*CNT_W-1:0] dw,
                                  input logic [N_CH-1:0] en,
                                  input logic [CNT_W-1:0] m,
                                  input logic [CNT_W-1:0] f);
    obs_t o;
    int   len = 0;
    int   d;
    for (int i = 0; i < N_CH; i++) begin
      d = en[i] ? int'(dw[i*CNT_W +: CNT_W]) : 0;
      o = '0;
      o.busy = 1'b1;
      o.cur_ch = IDX_W'(i);
      exp_q.push_back(o);
      len++;
      o.valve = N_CH'(1) << i;
      for (int k = 0; k < d; k++) begin
        exp_q.push_back(o);
        len++;
      end
    end
    o = '0;
    o.busy = 1'b1;
    o.mix = 1'b1;
    for (int k = 0; k < int'(m); k++) begin
      exp_q.push_back(o);
      len++;
    end
    o.mix = 1'b0;
    o.outlet = 1'b1;
    for (int k = 0; k < int'(f); k++) begin
      exp_q.push_back(o);
      len++;
    end
    o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    exp_q.push_back(o);
    len++;
    return len;
  endfunction

  // Reference model: cycle cyc is busy iff cyc <= busy_last.
  always @(posedge clk_i) begin
    cyc++;
    if (rst_ni === 1'b1) begin
      if (cyc <= busy_last) begin
        if (abort_i) begin
          exp_q.delete();
          ab_o = '0;
          ab_o.aborted = 1'b1;
          exp_q.push_back(ab_o);
          busy_last = cyc;
        end
      end else if (start_i && !abort_i) begin
        busy_last = cyc + push_run(dwell_i, ch_en_i, mix_cycles_i, flush_cycles_i);
      end
    end
  end

  always @(negedge rst_ni) begin
    exp_q.delete();
    busy_last = cyc;
  end

  // Monitor.
  always @(negedge clk_i) begin
    if (mon_en) begin
      act_o = '{valve: valve_o, mix: mix_en_o, outlet: outlet_open_o, cur_ch: cur_ch_o,
                busy: busy_o, done: done_o, aborted: aborted_o};
      if (exp_q.size() > 0) want_o = exp_q.pop_front();
      else want_o = '0;
      checks++;
      if (act_o !== want_o) begin
        errors++;
        $display("FAIL outputs at edge %0d+: got valve=%b mix=%b out=%b ch=%0d busy=%b done=%b abrt=%b, want valve=%b mix=%b out=%b ch=%0d busy=%b done=%b abrt=%b",
                 cyc, act_o.valve, act_o.mix, act_o.outlet, act_o.cur_ch, act_o.busy, act_o.done, act_o.aborted,
                 want_o.valve, want_o.mix, want_o.outlet, want_o.cur_ch, want_o.busy, want_o.done, want_o.aborted);
      end
      checks++;
      assert ($onehot0({valve_o, mix_en_o, outlet_open_o}))
      else begin
        errors++;
        $display("FAIL exclusivity: got valve=%b mix=%b out=%b, want at most one high",
                 valve_o, mix_en_o, outlet_open_o);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic set_cfg(input int d0, input int d1, input int d2,
                         input logic [N_CH-1:0] en, input int m, input int f);
    dwell_i        = {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    ch_en_i        = en;
    mix_cycles_i   = CNT_W'(m);
    flush_cycles_i = CNT_W'(f);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy_o && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy_o, budget);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    set_cfg(0, 0, 0, '0, 0, 0);
    tick(3);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Basic run and the masked-channel run.
    set_cfg(4, 0, 2, 3'b111, 5, 3);
    pulse_start();
    wait_idle(100);
    tick(2);
    set_cfg(2, 7, 4, 3'b010, 5, 3);
    pulse_start();
    wait_idle(100);
    tick(2);

    // All phases empty: only the three gaps and the done cycle.
    set_cfg(0, 0, 0, 3'b111, 0, 0);
    pulse_start();
    wait_idle(100);
    tick(1);

    // Abort during cycle 7, restart in cycle 9.
    set_cfg(4, 0, 2, 3'b111, 5, 3);
    pulse_start();
    tick(6);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
    set_cfg(1, 3, 0, 3'b011, 2, 0);
    pulse_start();
    wait_idle(100);
    tick(2);

    // Start and abort together in IDLE: both ignored.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    tick(3);

    // Start re-pulsed mid-run and during done, then held into the first IDLE.
    set_cfg(4, 0, 2, 3'b111, 5, 3);
    pulse_start();
    tick(2);
    pulse_start();
    begin
      int k = 0;
      while (!done_o && k < 100) begin
        tick();
        k++;
      end
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b, want 1", done_o);
    end
    start_i = 1'b1;
    tick(2);
    start_i = 1'b0;
    wait_idle(100);
    tick(2);

    // Asynchronous reset in cycle 12.
    set_cfg(4, 0, 2, 3'b111, 5, 3);
    pulse_start();
    tick(11);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({valve_o, mix_en_o, outlet_open_o, cur_ch_o, busy_o, done_o, aborted_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valve=%b mix=%b out=%b ch=%0d busy=%b done=%b abrt=%b, want all 0",
               valve_o, mix_en_o, outlet_open_o, cur_ch_o, busy_o, done_o, aborted_o);
    end
    tick(2);
    rst_ni = 1'b1;
    tick(2);
    set_cfg(1, 1, 1, 3'b101, 1, 1);
    pulse_start();
    wait_idle(100);
    tick(1);

    // Random traffic: config changes every cycle, sporadic start and abort.
    for (int c = 0; c < 3000; c++) begin
      dwell_i = {CNT_W'($urandom_range(0, 6)), CNT_W'($urandom_range(0, 6)),
                 CNT_W'($urandom_range(0, 6))};
      ch_en_i        = N_CH'($urandom_range(0, 7));
      mix_cycles_i   = CNT_W'($urandom_range(0, 5));
      flush_cycles_i = CNT_W'($urandom_range(0, 5));
      start_i        = ($urandom_range(0, 5) == 0);
      abort_i        = ($urandom_range(0, 49) == 0);
      tick();
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    wait_idle(200);
    tick(2);

    // Full-scale dwell on the only enabled channel.
    set_cfg(16'hFFFF, 3, 5, 3'b001, 0, 1);
    pulse_start();
    wait_idle(70000);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnode_dose_seq.md
# cnode_dose_seq

Parametrised dosing sequencer for an N-inlet concentration node. It serially opens one inlet valve at a time, each for a programmable dwell, then holds the mix phase for a fixed count (serpentine/diffusion-mixer residence time) and opens the outlet for a flush. It is the controlled, clocked successor to fixed-topology concentration nodes. It sits between the run controller and the valve/pump drivers of one node.

## Interface
Parameters:
- N_CH, 3, number of inlet channels (≥1)
- CNT_W, 16, width of each dwell count and of the mix/flush counts
- IDX_W, $clog2(N_CH) (min 1), width of cur_ch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled in IDLE only
- abort  in  1  cancel current run
- dwell  in  N_CH*CNT_W  valve-open cycles per channel; channel i at bits [i*CNT_W +: CNT_W]
- ch_en  in  N_CH  channel enable mask
- mix_cycles  in  CNT_W  mix-hold cycles (M)
- flush_cycles  in  CNT_W  outlet-open cycles (F)
- valve  out  N_CH  inlet valve drives, one-hot or zero
- mix_en  out  1  mix phase active
- outlet_open  out  1  outlet valve drive
- cur_ch  out  IDX_W  channel slot being dosed; 0 outside DOSE
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at run completion
- aborted  out  1  one-cycle pulse after abort

## Operation
- All outputs are registered. On reset: state IDLE and every output 0, including internal counters and latched config.
- The FSM has the states IDLE, DOSE_GAP, DOSE_OPEN, MIX, FLUSH, DONE.
- IDLE: start=1 and abort=0 latches dwell, ch_en, mix_cycles and flush_cycles, sets idx=0 and moves to DOSE_GAP. Input changes during a run have no effect.
- DOSE_GAP: one cycle per channel slot with all valves closed (break-before-make). Effective dwell D_i = ch_en[i] ? dwell_i : 0.
  - D_i > 0: go to DOSE_OPEN.
  - D_i = 0: advance to the next slot, or leave DOSE after the last slot.
- DOSE_OPEN: valve[idx]=1 for exactly D_i cycles, then advance idx to the next slot's DOSE_GAP. After slot N_CH-1, go to MIX.
- MIX: mix_en=1 for M cycles. With M=0 the state is skipped, taking zero cycles.
- FLUSH: outlet_open=1 for F cycles. With F=0 the state is skipped, taking zero cycles.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- abort=1 in any non-IDLE state:
  - On the next edge the state is IDLE and valve, mix_en, outlet_open, busy and done are all 0.
  - aborted=1 for one cycle.
  - A pending done is suppressed.
- abort in IDLE has no effect, and start is ignored in that cycle.
- start while busy is ignored and not queued. Once IDLE is reached, a start in the first IDLE cycle is accepted.
- Invariant: at most one of {any valve bit, mix_en, outlet_open} is high in any cycle.
- Counters are down-counters of width CNT_W. Dwell 2^CNT_W−1 must be honoured exactly with no wrap.

## Timing
- Cycle numbering: start is sampled at edge 0, and cycle k is the period after edge k−1. The first DOSE_GAP is cycle 1.
- Run length: busy is high for N_CH + ΣD_i + M + F cycles, then one DONE cycle. The run occupies cycles 1 through N_CH+ΣD_i+M+F+1.
- Latency from the start edge to the first valve open is 1 gap cycle, plus any gap cycles of preceding skipped slots.
- After done, busy drops on the following edge. The earliest restart is accepted in the first IDLE cycle.
- Asynchronous reset mid-run clears all outputs immediately, with no done and no aborted pulse.

## Test plan
- N_CH=3, dwell={4,0,2}, ch_en=3'b111, M=5, F=3; start at edge 0 -> the following must hold:
  - valve[0] cycles 2–5; gaps at 1, 6, 7; valve[2] cycles 8–9
  - mix_en 10–14; outlet_open 15–17; done at 18; busy 1–18
- Same config with ch_en=3'b010 and dwell[1]=7 -> gaps at 1, 2 (cur_ch=1) and 10; valve[1] cycles 3–9; mix_en 11–15; outlet_open 16–18; done at 19.
- All dwell=0, M=0, F=0 -> gap cycles 1–3, done at 4, no valve/mix/outlet activity.
- abort asserted during cycle 7 of the first scenario -> at edge 7 all drives are 0, aborted=1 in cycle 8, no done. A new start in cycle 9 is accepted.
- start re-pulsed during a run and while done=1 -> ignored; a start on the cycle after done begins a fresh run with identical timing.
- rst_n pulled low in cycle 12 of the first scenario -> outputs 0 asynchronously. After release, IDLE is entered and the mutual-exclusion invariant holds throughout (assertion).
